// File: rtl/line_burst_adapter.sv
// -----------------------------------------------------------------------------
// line_burst_adapter
//
// Splits each 256-bit cache-line request from the MMU into eight 32-bit word
// transfers on the narrow memory bus. Read words are collected into a line
// buffer and presented on data_o when the line completes. If the memory does
// not acknowledge a word within TIMEOUT cycles, the transfer is abandoned and
// the completion pulse carries bus_err_o.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   addr_i      line physical address (bits [4:0] ignored)
//   data_i      write line from the MMU
//   data_o      last completed read line (partial words zero on error)
//   rd_i, we_i  line read / write requests, level, held until ack_o
//   ack_o       one-cycle completion pulse
//   bus_err_o   high together with ack_o when the line was aborted
//   mem_addr_o  word address on the memory bus
//   mem_data_o  write word on the memory bus
//   mem_data_i  read word from the memory bus
//   mem_rd_o    word read strobe
//   mem_we_o    word write strobe
//   mem_ack_i   word complete; the current word is consumed at this edge
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module line_burst_adapter #(
    parameter int WORDS   = 8,
    parameter int TIMEOUT = 255,
    parameter int TO_BITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic [255:0] data_o,
    input  logic         rd_i,
    input  logic         we_i,
    output logic         ack_o,
    output logic         bus_err_o,
    output logic [31:0]  mem_addr_o,
    output logic [31:0]  mem_data_o,
    input  logic [31:0]  mem_data_i,
    output logic         mem_rd_o,
    output logic         mem_we_o,
    input  logic         mem_ack_i
);

    // Index of the final word of a line.
    localparam logic [2:0]         IDX_LAST  = 3'(WORDS - 32'sd1);
    // A zero TIMEOUT means "wait forever".
    localparam bit                 TO_EN     = (TIMEOUT != 32'sd0);
    localparam logic [TO_BITS-1:0] TIMEOUT_C = TIMEOUT[TO_BITS-1:0];
    localparam logic [TO_BITS-1:0] CNT_ONE   = {{(TO_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic               op_we_q,      op_we_d;
    logic [26:0]        base_q,       base_d;
    logic [2:0]         idx_q,        idx_d;
    logic [TO_BITS-1:0] cnt_q,        cnt_d;
    logic [255:0]       wbuf_q,       wbuf_d;
    logic [255:0]       rbuf_q,       rbuf_d;
    logic [255:0]       data_o_q,     data_o_d;
    logic [31:0]        mem_addr_q,   mem_addr_d;
    logic [31:0]        mem_data_q,   mem_data_d;
    logic               mem_rd_q,     mem_rd_d;
    logic               mem_we_q,     mem_we_d;
    logic               ack_q,        ack_d;
    logic               bus_err_q,    bus_err_d;

    // The low address bits select a byte within the line and are dropped.
    logic               addr_lsb_unused;
    assign addr_lsb_unused = ^addr_i[4:0];

    // Next-state and next-output computation for the line sequencer.
    always_comb begin
        state_d    = state_q;
        op_we_d    = op_we_q;
        base_d     = base_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        wbuf_d     = wbuf_q;
        rbuf_d     = rbuf_q;
        data_o_d   = data_o_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_rd_d   = mem_rd_q;
        mem_we_d   = mem_we_q;
        ack_d      = 1'b0;
        bus_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rd_i || we_i) begin
                    // Write has priority when both requests are raised.
                    op_we_d    = we_i;
                    base_d     = addr_i[31:5];
                    idx_d      = 3'd0;
                    cnt_d      = {TO_BITS{1'b0}};
                    // Cleared so that words never received on abort read as 0.
                    rbuf_d     = 256'd0;
                    mem_addr_d = {addr_i[31:5], 5'd0};
                    mem_rd_d   = ~we_i;
                    mem_we_d   = we_i;
                    state_d    = S_XFER;
                    if (we_i) begin
                        wbuf_d     = data_i;
                        mem_data_d = data_i[31:0];
                    end else begin
                        wbuf_d     = wbuf_q;
                        mem_data_d = wbuf_q[31:0];
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_XFER: begin
                if (mem_ack_i) begin
                    cnt_d = {TO_BITS{1'b0}};
                    if (!op_we_q) begin
                        rbuf_d[{idx_q, 5'd0} +: 32] = mem_data_i;
                    end else begin
                        rbuf_d = rbuf_q;
                    end
                    if (idx_q == IDX_LAST) begin
                        mem_rd_d  = 1'b0;
                        mem_we_d  = 1'b0;
                        ack_d     = 1'b1;
                        bus_err_d = 1'b0;
                        state_d   = S_ACK;
                        if (!op_we_q) begin
                            data_o_d = rbuf_d;
                        end else begin
                            data_o_d = data_o_q;
                        end
                    end else begin
                        // Advance to the next word with the strobe still
                        // asserted, so consecutive words have no idle gap.
                        idx_d      = 3'(idx_q + 3'd1);
                        mem_addr_d = {base_q, idx_d, 2'b00};
                        mem_data_d = wbuf_q[{idx_d, 5'd0} +: 32];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (TO_EN && (cnt_d == TIMEOUT_C)) begin
                        mem_rd_d  = 1'b0;
                        mem_we_d  = 1'b0;
                        ack_d     = 1'b1;
                        bus_err_d = 1'b1;
                        state_d   = S_ACK;
                        if (!op_we_q) begin
                            data_o_d = rbuf_q;
                        end else begin
                            data_o_d = data_o_q;
                        end
                    end else begin
                        state_d = S_XFER;
                    end
                end
            end

            S_ACK: begin
                // Requests are not sampled here; the MMU is still releasing
                // the one just acknowledged.
                state_d = S_IDLE;
            end

            default: begin
                state_d  = S_IDLE;
                mem_rd_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            op_we_q    <= 1'b0;
            base_q     <= 27'd0;
            idx_q      <= 3'd0;
            cnt_q      <= {TO_BITS{1'b0}};
            wbuf_q     <= 256'd0;
            rbuf_q     <= 256'd0;
            data_o_q   <= 256'd0;
            mem_addr_q <= 32'd0;
            mem_data_q <= 32'd0;
            mem_rd_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            ack_q      <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_we_q    <= op_we_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            wbuf_q     <= wbuf_d;
            rbuf_q     <= rbuf_d;
            data_o_q   <= data_o_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_rd_q   <= mem_rd_d;
            mem_we_q   <= mem_we_d;
            ack_q      <= ack_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign data_o     = data_o_q;
    assign ack_o      = ack_q;
    assign bus_err_o  = bus_err_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign mem_rd_o   = mem_rd_q;
    assign mem_we_o   = mem_we_q;

endmodule

// File: tb/tb_line_burst_adapter.sv
// -----------------------------------------------------------------------------
// Directed testbench for line_burst_adapter. Inputs are driven and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge. A small
// memory responder returns rd_base + word-offset for every read word.
// -----------------------------------------------------------------------------
module tb_line_burst_adapter;

    logic         clk;
    logic         rst;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic [255:0] data_o;
    logic         rd_i;
    logic         we_i;
    logic         ack_o;
    logic         bus_err_o;
    logic [31:0]  mem_addr_o;
    logic [31:0]  mem_data_o;
    logic [31:0]  mem_data_i;
    logic         mem_rd_o;
    logic         mem_we_o;
    logic         mem_ack_i;

    logic [31:0]  rd_base;
    logic [255:0] last_line;
    int           n_checks = 0;
    int           n_pass   = 0;
    int           ack_total = 0;
    int           rd_total  = 0;
    int           wr_total  = 0;
    logic [31:0]  wlog_addr [0:63];
    logic [31:0]  wlog_data [0:63];

    line_burst_adapter #(
        .WORDS   (8),
        .TIMEOUT (4),
        .TO_BITS (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .rd_i       (rd_i),
        .we_i       (we_i),
        .ack_o      (ack_o),
        .bus_err_o  (bus_err_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i),
        .mem_rd_o   (mem_rd_o),
        .mem_we_o   (mem_we_o),
        .mem_ack_i  (mem_ack_i)
    );

    // Memory read model: word k of a line returns rd_base + k.
    assign mem_data_i = rd_base + {29'd0, mem_addr_o[4:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus monitor: counts ack pulses, read strobes and logs accepted writes.
    always @(posedge clk) begin
        if (ack_o) ack_total <= ack_total + 1;
        if (mem_rd_o) rd_total <= rd_total + 1;
        if (mem_we_o && mem_ack_i) begin
            wlog_addr[wr_total & 63] <= mem_addr_o;
            wlog_data[wr_total & 63] <= mem_data_o;
            wr_total <= wr_total + 1;
        end
    end

    task automatic wait_ack(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack_o) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rd_i = 1'b0; we_i = 1'b0; addr_i = 32'd0;
        data_i = 256'd0; mem_ack_i = 1'b0; rd_base = 32'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (data_o !== 256'd0) $display("FAIL reset_data_o: got %h want 0", data_o);
        else n_pass++;
        n_checks++;
        if ({ack_o, bus_err_o, mem_rd_o, mem_we_o} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b want 0000", {ack_o, bus_err_o, mem_rd_o, mem_we_o});
        else n_pass++;
        n_checks++;
        if ({mem_addr_o, mem_data_o} !== 64'd0)
            $display("FAIL reset_bus: got %h want 0", {mem_addr_o, mem_data_o});
        else n_pass++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ack_o, mem_rd_o, mem_we_o} !== 3'b000)
            $display("FAIL idle_after_reset: got %b want 000", {ack_o, mem_rd_o, mem_we_o});
        else n_pass++;
    endtask

    task automatic test_read();
        int a0;
        logic [255:0] exp;
        a0 = ack_total;
        rd_base = 32'hA000_0000; addr_i = 32'h0000_1234; rd_i = 1'b1; mem_ack_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (mem_addr_o !== 32'h0000_1220 + 32'(4 * k) || mem_rd_o !== 1'b1 ||
                mem_we_o !== 1'b0 || ack_o !== 1'b0)
                $display("FAIL read_word%0d: got addr %h rd %b we %b ack %b want addr %h rd 1 we 0 ack 0",
                         k, mem_addr_o, mem_rd_o, mem_we_o, ack_o, 32'h0000_1220 + 32'(4 * k));
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (ack_o !== 1'b1 || bus_err_o !== 1'b0)
            $display("FAIL read_ack: got ack %b err %b want 1 0", ack_o, bus_err_o);
        else n_pass++;
        for (int k = 0; k < 8; k++) exp[32*k +: 32] = 32'hA000_0000 + 32'(k);
        n_checks++;
        if (data_o[31:0] !== 32'hA000_0000 || data_o[255:224] !== 32'hA000_0007)
            $display("FAIL read_edge_words: got %h %h want a0000000 a0000007", data_o[31:0], data_o[255:224]);
        else n_pass++;
        n_checks++;
        if (data_o !== exp) $display("FAIL read_line: got %h want %h", data_o, exp);
        else n_pass++;
        last_line = exp;
        rd_i = 1'b0; mem_ack_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ack_o !== 1'b0 || ack_total - a0 !== 1)
            $display("FAIL read_single_ack: got ack %b pulses %0d want 0 1", ack_o, ack_total - a0);
        else n_pass++;
    endtask

    task automatic test_write();
        int a0, w0;
        bit got, gap;
        a0 = ack_total; w0 = wr_total; got = 1'b0; gap = 1'b0;
        for (int k = 0; k < 8; k++) data_i[32*k +: 32] = 32'h1111_1111 * 32'(k);
        addr_i = 32'h8000_0040; we_i = 1'b1; mem_ack_i = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ack_o) begin
                got = 1'b1;
                break;
            end
            if (!mem_we_o || mem_rd_o) gap = 1'b1;
            mem_ack_i = (c % 3 == 2);
        end
        n_checks++;
        if (!got || bus_err_o !== 1'b0)
            $display("FAIL write_ack: got ack %b err %b want 1 0", got, bus_err_o);
        else n_pass++;
        mem_ack_i = 1'b0; we_i = 1'b0;
        n_checks++;
        if (gap) $display("FAIL write_strobe_held: got gap 1 want 0");
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (wlog_addr[(w0 + k) & 63] !== 32'h8000_0040 + 32'(4 * k) ||
                wlog_data[(w0 + k) & 63] !== 32'h1111_1111 * 32'(k))
                $display("FAIL write_word%0d: got %h:%h want %h:%h", k,
                         wlog_addr[(w0 + k) & 63], wlog_data[(w0 + k) & 63],
                         32'h8000_0040 + 32'(4 * k), 32'h1111_1111 * 32'(k));
            else n_pass++;
        end
        n_checks++;
        if (data_o !== last_line) $display("FAIL write_data_o_held: got %h want %h", data_o, last_line);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (wr_total - w0 !== 8 || ack_total - a0 !== 1)
            $display("FAIL write_counts: got words %0d acks %0d want 8 1", wr_total - w0, ack_total - a0);
        else n_pass++;
    endtask

    task automatic test_both();
        int a0, w0, r0;
        bit got;
        a0 = ack_total; w0 = wr_total; r0 = rd_total;
        for (int k = 0; k < 8; k++) data_i[32*k +: 32] = 32'hC0DE_0000 + 32'(k);
        addr_i = 32'h0000_0100; rd_i = 1'b1; we_i = 1'b1; mem_ack_i = 1'b1;
        wait_ack(got);
        n_checks++;
        if (!got || bus_err_o !== 1'b0) $display("FAIL both_ack: got ack %b err %b want 1 0", got, bus_err_o);
        else n_pass++;
        rd_i = 1'b0; we_i = 1'b0; mem_ack_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rd_total !== r0) $display("FAIL both_no_read: got %0d read strobes want 0", rd_total - r0);
        else n_pass++;
        n_checks++;
        if (wr_total - w0 !== 8 || wlog_addr[(w0 + 7) & 63] !== 32'h0000_011C ||
            wlog_data[(w0 + 7) & 63] !== 32'hC0DE_0007)
            $display("FAIL both_write: got %0d words last %h:%h want 8 0000011c:c0de0007",
                     wr_total - w0, wlog_addr[(w0 + 7) & 63], wlog_data[(w0 + 7) & 63]);
        else n_pass++;
        n_checks++;
        if (ack_total - a0 !== 1) $display("FAIL both_acks: got %0d want 1", ack_total - a0);
        else n_pass++;
    endtask

    task automatic test_timeout();
        logic [255:0] exp;
        bit got;
        rd_base = 32'hB000_0000; addr_i = 32'h0000_2000; rd_i = 1'b1; mem_ack_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 3) mem_ack_i = 1'b0;
            if (k == 6) begin
                n_checks++;
                if (mem_rd_o !== 1'b1 || ack_o !== 1'b0)
                    $display("FAIL timeout_stall3: got rd %b ack %b want 1 0", mem_rd_o, ack_o);
                else n_pass++;
            end
        end
        @(negedge clk);
        n_checks++;
        if (ack_o !== 1'b1 || bus_err_o !== 1'b1 || mem_rd_o !== 1'b0)
            $display("FAIL timeout_abort: got ack %b err %b rd %b want 1 1 0", ack_o, bus_err_o, mem_rd_o);
        else n_pass++;
        exp = 256'd0;
        for (int k = 0; k < 3; k++) exp[32*k +: 32] = 32'hB000_0000 + 32'(k);
        n_checks++;
        if (data_o !== exp) $display("FAIL timeout_partial: got %h want %h", data_o, exp);
        else n_pass++;
        rd_i = 1'b0;
        @(negedge clk);
        rd_base = 32'hD000_0000; addr_i = 32'h0000_3000; rd_i = 1'b1; mem_ack_i = 1'b1;
        wait_ack(got);
        n_checks++;
        if (!got || bus_err_o !== 1'b0 || data_o[255:224] !== 32'hD000_0007 || data_o[127:96] !== 32'hD000_0003)
            $display("FAIL timeout_recover: got ack %b err %b w7 %h w3 %h want 1 0 d0000007 d0000003",
                     got, bus_err_o, data_o[255:224], data_o[127:96]);
        else n_pass++;
        rd_i = 1'b0; mem_ack_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int a0;
        bit got;
        a0 = ack_total;
        rd_base = 32'hE000_0000; addr_i = 32'h0000_4000; rd_i = 1'b1; mem_ack_i = 1'b1;
        for (int k = 0; k < 6; k++) @(negedge clk);
        n_checks++;
        if (mem_addr_o !== 32'h0000_4014) $display("FAIL rstmid_word5: got %h want 00004014", mem_addr_o);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({data_o, mem_addr_o, mem_data_o, ack_o, bus_err_o, mem_rd_o, mem_we_o} !== 324'd0)
            $display("FAIL rstmid_async: got addr %h rd %b data_o %h want all 0", mem_addr_o, mem_rd_o, data_o);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_addr_o !== 32'h0000_4000 || mem_rd_o !== 1'b1)
            $display("FAIL rstmid_restart: got addr %h rd %b want 00004000 1", mem_addr_o, mem_rd_o);
        else n_pass++;
        wait_ack(got);
        n_checks++;
        if (!got || data_o[31:0] !== 32'hE000_0000 || data_o[255:224] !== 32'hE000_0007)
            $display("FAIL rstmid_line: got ack %b w0 %h w7 %h want 1 e0000000 e0000007",
                     got, data_o[31:0], data_o[255:224]);
        else n_pass++;
        rd_i = 1'b0; mem_ack_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ack_total - a0 !== 1) $display("FAIL rstmid_acks: got %0d want 1", ack_total - a0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int a0;
        bit got;
        a0 = ack_total;
        rd_base = 32'hF000_0000; addr_i = 32'h0000_5000; rd_i = 1'b1; mem_ack_i = 1'b1;
        wait_ack(got);
        n_checks++;
        if (!got) $display("FAIL b2b_first_ack: got 0 want 1");
        else n_pass++;
        addr_i = 32'h0000_6000;
        @(negedge clk);
        n_checks++;
        if (mem_rd_o !== 1'b0 || ack_o !== 1'b0)
            $display("FAIL b2b_idle_gap: got rd %b ack %b want 0 0", mem_rd_o, ack_o);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (mem_addr_o !== 32'h0000_6000 || mem_rd_o !== 1'b1)
            $display("FAIL b2b_second_start: got addr %h rd %b want 00006000 1", mem_addr_o, mem_rd_o);
        else n_pass++;
        wait_ack(got);
        n_checks++;
        if (!got || data_o[63:32] !== 32'hF000_0001)
            $display("FAIL b2b_second_ack: got ack %b w1 %h want 1 f0000001", got, data_o[63:32]);
        else n_pass++;
        rd_i = 1'b0; mem_ack_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ack_total - a0 !== 2) $display("FAIL b2b_acks: got %0d want 2", ack_total - a0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_both();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
